// File: rtl/metadata_pkg.sv
// Shared widths, per-word metadata record and sequencer state encoding
// for the metadata word sequencer and its offset accumulator.
package metadata_pkg;

  localparam int L2_WIDTH         = 512;
  localparam int WordWidth_WIDTH  = 32;
  localparam int NumOfBytesInWord = 4;
  localparam int MAXNUMWORD       = 32;
  localparam int BW_WIDTH         = 5;
  localparam int OFFSET_WIDTH     = 10;
  localparam int NUMWORDS_WIDTH   = 6;
  localparam int INDEX_WIDTH      = 5;

  typedef struct packed {
    logic [BW_WIDTH-1:0]         bitWidth;
    logic [WordWidth_WIDTH-1:0]  Mid;
    logic                        Conv;
    logic [NumOfBytesInWord-1:0] isBool;
  } word_meta_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_t;

  // Word counts above the array depth are treated as a full block.
  function automatic logic [NUMWORDS_WIDTH-1:0] clamp_words(input logic [NUMWORDS_WIDTH-1:0] n);
    return (n > NUMWORDS_WIDTH'(MAXNUMWORD)) ? NUMWORDS_WIDTH'(MAXNUMWORD) : n;
  endfunction

endpackage

// File: rtl/metadata_offset_accum.sv
// Running bit offset of the current word inside the packed L2 line, with a
// sticky flag raised once an accepted word would spill past the line end.
module metadata_offset_accum
  import metadata_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [BW_WIDTH-1:0]     bit_width,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    overflow
);

  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic                    overflow_q, overflow_d;
  logic [OFFSET_WIDTH:0]   sum;

  always_comb begin
    sum        = {1'b0, offset_q} + (OFFSET_WIDTH+1)'(bit_width);
    offset_d   = offset_q;
    overflow_d = overflow_q;
    if (clear) begin
      offset_d   = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      offset_d = sum[OFFSET_WIDTH-1:0];
      if (sum > (OFFSET_WIDTH+1)'(L2_WIDTH)) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      offset_q   <= offset_d;
      overflow_q <= overflow_d;
    end
  end

  assign offset   = offset_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/metadata_word_sequencer.sv
// Captures one rotated metadata set per block and streams it out one word
// per handshake, tagging each word with its index and packed bit offset.
module metadata_word_sequencer
  import metadata_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic [NUMWORDS_WIDTH-1:0]              numWords,
  input  logic [BW_WIDTH*MAXNUMWORD-1:0]         bitWidthArray,
  input  logic [WordWidth_WIDTH*MAXNUMWORD-1:0]  MidArray,
  input  logic [MAXNUMWORD-1:0]                  ConvArray,
  input  logic [NumOfBytesInWord*MAXNUMWORD-1:0] isBoolArray,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BW_WIDTH-1:0]                    out_bitWidth,
  output logic [WordWidth_WIDTH-1:0]             out_Mid,
  output logic                                   out_Conv,
  output logic [NumOfBytesInWord-1:0]            out_isBool,
  output logic [INDEX_WIDTH-1:0]                 out_index,
  output logic [OFFSET_WIDTH-1:0]                out_bitOffset,
  output logic                                   out_last,
  output logic                                   done,
  output logic                                   overflow,
  output logic                                   busy
);

  seq_state_t                       state_q, state_d;
  word_meta_t [MAXNUMWORD-1:0]      meta_q, meta_d, load_meta;
  logic [NUMWORDS_WIDTH-1:0]        remaining_q, remaining_d, load_count;
  logic [INDEX_WIDTH-1:0]           index_q, index_d;
  logic                             out_valid_q, out_valid_d;
  logic                             load_ready_q, load_ready_d;
  logic                             out_last_q, out_last_d;
  logic                             done_q, done_d;
  logic                             clear, accept;
  word_meta_t                       cur;

  generate
    for (genvar gi = 0; gi < MAXNUMWORD; gi++) begin : g_unpack
      assign load_meta[gi] = '{
        bitWidth: bitWidthArray[gi*BW_WIDTH +: BW_WIDTH],
        Mid:      MidArray[gi*WordWidth_WIDTH +: WordWidth_WIDTH],
        Conv:     ConvArray[gi],
        isBool:   isBoolArray[gi*NumOfBytesInWord +: NumOfBytesInWord]
      };
    end
  endgenerate

  assign load_count = clamp_words(numWords);
  assign cur        = meta_q[0];

  always_comb begin
    state_d     = state_q;
    meta_d      = meta_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          meta_d      = load_meta;
          remaining_d = load_count;
          index_d     = '0;
          clear       = 1'b1;
          // An empty block completes immediately without emitting a word.
          if (load_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          accept      = 1'b1;
          meta_d      = {word_meta_t'('0), meta_q[MAXNUMWORD-1:1]};
          index_d     = index_q + INDEX_WIDTH'(1);
          remaining_d = remaining_q - NUMWORDS_WIDTH'(1);
          if (remaining_q == NUMWORDS_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d  = (state_d == STREAM);
    load_ready_d = (state_d == IDLE);
    out_last_d   = (state_d == STREAM) && (remaining_d == NUMWORDS_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      meta_q       <= '0;
      remaining_q  <= '0;
      index_q      <= '0;
      out_valid_q  <= 1'b0;
      load_ready_q <= 1'b1;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      meta_q       <= meta_d;
      remaining_q  <= remaining_d;
      index_q      <= index_d;
      out_valid_q  <= out_valid_d;
      load_ready_q <= load_ready_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
    end
  end

  metadata_offset_accum u_offset_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .accept    (accept),
    .bit_width (cur.bitWidth),
    .offset    (out_bitOffset),
    .overflow  (overflow)
  );

  assign load_ready   = load_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = out_valid_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign out_index    = index_q;
  assign out_bitWidth = cur.bitWidth;
  assign out_Mid      = cur.Mid;
  assign out_Conv     = cur.Conv;
  assign out_isBool   = cur.isBool;

endmodule

// File: tb/tb_metadata_word_sequencer.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops
// and compares every accepted word, and tracks done pulses.
`timescale 1ns/1ps
module tb_metadata_word_sequencer;
  import metadata_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [5:0]   numWords = '0;
  logic [159:0] bitWidthArray = '0;
  logic [1023:0] MidArray = '0;
  logic [31:0]  ConvArray = '0;
  logic [127:0] isBoolArray = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [4:0]   out_bitWidth;
  logic [31:0]  out_Mid;
  logic         out_Conv;
  logic [3:0]   out_isBool;
  logic [4:0]   out_index;
  logic [9:0]   out_bitOffset;
  logic         out_last;
  logic         done;
  logic         overflow;
  logic         busy;

  always #5 clk = ~clk;

  metadata_word_sequencer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .numWords(numWords), .bitWidthArray(bitWidthArray), .MidArray(MidArray),
    .ConvArray(ConvArray), .isBoolArray(isBoolArray), .out_valid(out_valid),
    .out_ready(out_ready), .out_bitWidth(out_bitWidth), .out_Mid(out_Mid),
    .out_Conv(out_Conv), .out_isBool(out_isBool), .out_index(out_index),
    .out_bitOffset(out_bitOffset), .out_last(out_last), .done(done),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [4:0]  bw;
    logic [31:0] mid;
    logic        conv;
    logic [3:0]  isb;
    logic [4:0]  idx;
    logic [9:0]  off;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   words_seen = 0;
  bit   done_due = 1'b0;
  int   bw_tab[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  // Monitor: compares each accepted word against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) done_cnt++;
      if (done_due) begin
        check("done_after_last", done, 1);
        check("load_ready_after_last", load_ready, 1);
        done_due = 1'b0;
      end
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=index%0d required=none", out_index);
        end else begin
          e = exp_q.pop_front();
          check("bitWidth", out_bitWidth, e.bw);
          check("Mid", out_Mid, e.mid);
          check("Conv", out_Conv, e.conv);
          check("isBool", out_isBool, e.isb);
          check("index", out_index, e.idx);
          check("bitOffset", out_bitOffset, e.off);
          check("last", out_last, e.last);
          check("overflow", overflow, e.ovf);
          check("busy", busy, 1);
          $display("word idx=%0d bw=%0d off=%0d last=%0d ovf=%0d", out_index, out_bitWidth, out_bitOffset, out_last, overflow);
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  task automatic set_inputs(input int n, input int tag);
    numWords = 6'(n);
    for (int i = 0; i < 32; i++) begin
      bitWidthArray[i*5 +: 5] = 5'(bw_tab[i]);
      MidArray[i*32 +: 32]    = 32'hA000_0000 + 32'(tag << 16) + 32'(i);
      ConvArray[i]            = 1'((i + tag) & 1);
      isBoolArray[i*4 +: 4]   = 4'(i ^ tag);
    end
  endtask

  task automatic push_expected(input int n, input int tag);
    exp_t e;
    int cnt;
    int off;
    cnt = (n > 32) ? 32 : n;
    off = 0;
    for (int i = 0; i < cnt; i++) begin
      e.bw   = 5'(bw_tab[i]);
      e.mid  = 32'hA000_0000 + 32'(tag << 16) + 32'(i);
      e.conv = 1'((i + tag) & 1);
      e.isb  = 4'(i ^ tag);
      e.idx  = 5'(i);
      e.off  = 10'(off);
      e.last = (i == cnt - 1);
      e.ovf  = (off > 512);
      exp_q.push_back(e);
      off += bw_tab[i];
    end
  endtask

  // Called at posedge+1; returns at the negedge after the load handshake.
  task automatic do_load(input int n, input int tag);
    int k;
    set_inputs(n, tag);
    push_expected(n, tag);
    load_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (load_ready) break;
      @(posedge clk); #1;
    end
    if (k == 200) fail_now("load_ready_wait");
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    check("first_valid_latency", out_valid, (n > 0));
    if (n == 0) begin
      check("empty_done", done, 1);
      check("empty_load_ready", load_ready, 1);
      check("empty_overflow_clear", overflow, 0);
    end
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    if (k == 500) fail_now("drain_wait");
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int w0;
    int k;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_load_ready", load_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_offset", out_bitOffset, 0);
    check("rst_mid", out_Mid, 0);
    @(posedge clk); #1;

    // Test 1: four words, offsets 0,3,10,10
    for (int i = 0; i < 32; i++) bw_tab[i] = 0;
    bw_tab[0] = 3; bw_tab[1] = 7; bw_tab[2] = 0; bw_tab[3] = 5;
    d0 = done_cnt;
    do_load(4, 1);
    wait_drain();
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_overflow", overflow, 0);

    // Test 2: stall three cycles at index 1
    d0 = done_cnt;
    do_load(4, 2);
    for (k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd1) break;
    end
    if (k == 10) fail_now("t2_index1_wait");
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_valid", out_valid, 1);
      check("t2_stall_index", out_index, 1);
      check("t2_stall_offset", out_bitOffset, 3);
      check("t2_stall_mid", out_Mid, 32'hA002_0001);
      check("t2_stall_bw", out_bitWidth, 7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
    check("t2_done_count", done_cnt - d0, 1);

    // Test 3: 32 words of 31 bits, overflow from index 17 onward
    for (int i = 0; i < 32; i++) bw_tab[i] = 31;
    d0 = done_cnt;
    do_load(32, 3);
    wait_drain();
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_overflow_sticky", overflow, 1);

    // Test 4: empty block, then clamped 40-word block
    d0 = done_cnt;
    do_load(0, 4);
    wait_drain();
    check("t4_empty_done_count", done_cnt - d0, 1);
    check("t4_empty_ready", load_ready, 1);
    for (int i = 0; i < 32; i++) bw_tab[i] = i % 8;
    w0 = words_seen;
    do_load(40, 5);
    wait_drain();
    check("t4_clamped_words", words_seen - w0, 32);

    // Test 5: reset during index 5 of a 10-word block
    for (int i = 0; i < 32; i++) bw_tab[i] = (i % 16) + 1;
    do_load(10, 6);
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd5) break;
    end
    if (k == 20) fail_now("t5_index5_wait");
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", out_valid, 0);
    check("t5_ready_after_rst", load_ready, 1);
    check("t5_overflow_after_rst", overflow, 0);
    check("t5_done_after_rst", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("t5_no_done_count", done_cnt - d0, 0);
    do_load(3, 7);
    wait_drain();

    // Test 6: load_valid held through STREAM with a second set
    for (int i = 0; i < 32; i++) bw_tab[i] = 0;
    bw_tab[0] = 3; bw_tab[1] = 7; bw_tab[2] = 0; bw_tab[3] = 5;
    d0 = done_cnt;
    set_inputs(4, 8);
    push_expected(4, 8);
    load_valid = 1'b1;
    @(posedge clk); #1;
    bw_tab[0] = 1; bw_tab[1] = 2; bw_tab[2] = 3; bw_tab[3] = 9;
    set_inputs(3, 9);
    push_expected(3, 9);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 50) fail_now("t6_done_wait");
    @(negedge clk);
    check("t6_second_valid", out_valid, 1);
    check("t6_second_index", out_index, 0);
    check("t6_second_mid", out_Mid, 32'hA009_0000);
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_drain();
    check("t6_done_count", done_cnt - d0, 2);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
